// File: rtl/mm_write_sink.sv
// Write-bus sink: captures in-range writes into a FIFO, streams them out as
// valid/ready, and keeps drop / overflow / data!=address statistics.
module mm_write_sink #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int DEPTH   = 8,
    parameter int ADDR_LO = 0,
    parameter int ADDR_HI = 98
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [AW-1:0]           address,
    input  logic                    write,
    input  logic [DW-1:0]           writedata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW-1:0]           out_addr,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    overflow,
    output logic [7:0]              drop_cnt,
    output logic [7:0]              mismatch_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_LAST = LW'(DEPTH - 1);
    // Signed one-bit-wider bounds keep the range check meaningful when ADDR_LO is 0.
    localparam logic signed [AW:0] LO_S = (AW+1)'(ADDR_LO);
    localparam logic signed [AW:0] HI_S = (AW+1)'(ADDR_HI);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        drop_q, drop_d, mis_q, mis_d;
    logic [AW-1:0]     amem_q [DEPTH];
    logic [DW-1:0]     dmem_q [DEPTH];

    logic signed [AW:0] addr_s;
    logic in_range, push_req, pop, push, lost;

    always_comb begin
        addr_s   = $signed({1'b0, address});
        in_range = (addr_s >= LO_S) && (addr_s <= HI_S);
        push_req = write && in_range;
        pop      = out_valid && out_ready;
        push     = push_req && (!full || pop);
        lost     = push_req && !push;
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        mis_d   = mis_q;

        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;

        if (lost) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        if (push && (writedata != address) && (mis_q != 8'hFF))
            mis_d = mis_q + 8'd1;

        case (state_q)
            S_EMPTY:   if (push) state_d = S_PARTIAL;
            S_PARTIAL: begin
                if (push && !pop && level_q == LVL_LAST) state_d = S_FULL;
                else if (pop && !push && level_q == LW'(1)) state_d = S_EMPTY;
            end
            S_FULL:    if (pop && !push) state_d = S_PARTIAL;
            default:   state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_EMPTY;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            mis_q   <= mis_d;
        end
    end

    // Storage needs no reset: only slots covered by level are ever presented.
    always_ff @(posedge CLK) begin
        if (!reset && push) begin
            amem_q[wr_q] <= address;
            dmem_q[wr_q] <= writedata;
        end
    end

    assign out_valid    = (state_q != S_EMPTY);
    assign full         = (state_q == S_FULL);
    assign level        = level_q;
    assign out_addr     = amem_q[rd_q];
    assign out_data     = dmem_q[rd_q];
    assign overflow     = ovf_q;
    assign drop_cnt     = drop_q;
    assign mismatch_cnt = mis_q;
endmodule

// File: tb/tb_mm_write_sink.sv
// Directed bench for mm_write_sink (default parameters, DEPTH=8).
module tb_mm_write_sink;
    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address = '0;
    logic       write = 1'b0;
    logic [7:0] writedata = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic [3:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic [7:0] mismatch_cnt;

    int checks = 0;
    int errors = 0;

    mm_write_sink dut (
        .CLK(CLK), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .level(level), .full(full),
        .overflow(overflow), .drop_cnt(drop_cnt), .mismatch_cnt(mismatch_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic en, input logic [7:0] a, input logic [7:0] d);
        write = en;
        address = a;
        writedata = d;
    endtask

    initial begin
        // reset state
        tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_mis", mismatch_cnt, 0);

        // master pattern: write / nop alternating, streaming out
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, 8'(i), 8'(i));
            #1 chk($sformatf("nocomb_valid%0d", i), out_valid, 0);
            tick();
            chk($sformatf("pat_valid%0d", i), out_valid, 1);
            chk($sformatf("pat_addr%0d", i), out_addr, i);
            chk($sformatf("pat_data%0d", i), out_data, i);
            wr(1'b0, 8'd0, 8'd0);
            tick();
            chk($sformatf("pat_empty%0d", i), out_valid, 0);
        end
        chk("pat_mis", mismatch_cnt, 0);
        chk("pat_drop", drop_cnt, 0);
        chk("pat_ovf", overflow, 0);

        // fill past full with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr(1'b1, 8'(i), 8'(i));
            tick();
            chk($sformatf("fill_level%0d", i), level, (i < 8) ? i + 1 : 8);
            chk($sformatf("fill_full%0d", i), full, (i >= 7) ? 1 : 0);
        end
        wr(1'b0, 8'd0, 8'd0);
        chk("fill_drop", drop_cnt, 2);
        chk("fill_ovf", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid%0d", i), out_valid, 1);
            chk($sformatf("drain_addr%0d", i), out_addr, i);
            tick();
        end
        chk("drain_empty", out_valid, 0);

        // push into a full FIFO while popping
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, 8'(10 + i), 8'(10 + i));
            tick();
        end
        chk("refill_full", full, 1);
        wr(1'b1, 8'd5, 8'd5);
        out_ready = 1'b1;
        tick();
        wr(1'b0, 8'd0, 8'd0);
        out_ready = 1'b0;
        chk("swap_level", level, 8);
        chk("swap_full", full, 1);
        chk("swap_drop", drop_cnt, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("swap_addr%0d", i), out_addr, (i < 7) ? 11 + i : 5);
            chk($sformatf("swap_data%0d", i), out_data, (i < 7) ? 11 + i : 5);
            tick();
        end
        chk("swap_empty", out_valid, 0);

        // out-of-range writes are ignored
        out_ready = 1'b0;
        wr(1'b1, 8'd99, 8'd1);
        tick();
        wr(1'b1, 8'd200, 8'd200);
        tick();
        wr(1'b0, 8'd0, 8'd0);
        chk("oor_level", level, 0);
        chk("oor_valid", out_valid, 0);
        chk("oor_drop", drop_cnt, 2);
        chk("oor_mis", mismatch_cnt, 0);

        // mismatched data stored and counted
        wr(1'b1, 8'd3, 8'd7);
        tick();
        wr(1'b0, 8'd0, 8'd0);
        chk("mis_addr", out_addr, 3);
        chk("mis_data", out_data, 7);
        chk("mis_cnt1", mismatch_cnt, 1);
        out_ready = 1'b1;
        tick();
        chk("mis_empty", out_valid, 0);
        for (int i = 0; i < 300; i++) begin
            wr(1'b1, 8'(i % 99), 8'((i % 99) ^ 1));
            tick();
            if (i == 99)  chk("mis_cnt101", mismatch_cnt, 101);
            if (i == 252) chk("mis_cnt254", mismatch_cnt, 254);
            if (i == 253) chk("mis_cnt255", mismatch_cnt, 255);
        end
        wr(1'b0, 8'd0, 8'd0);
        chk("mis_sat", mismatch_cnt, 255);
        chk("mis_level", level, 1);
        chk("mis_drop", drop_cnt, 2);
        tick();

        // reset mid-stream discards contents; concurrent write not captured
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(1'b1, 8'(20 + i), 8'(20 + i));
            tick();
        end
        chk("pre_rst_level", level, 3);
        wr(1'b1, 8'd23, 8'd23);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(1'b0, 8'd0, 8'd0);
        chk("mrst_level", level, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_full", full, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_drop", drop_cnt, 0);
        chk("mrst_mis", mismatch_cnt, 0);
        tick();
        chk("mrst_level2", level, 0);
        chk("mrst_valid2", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
